// File: rtl/lcd_panel_model.sv
// Responder side of an HD44780-style parallel LCD bus: decodes the instruction subset used by
// the clock display, mirrors a 32-byte DDRAM, emulates busy timing and answers bus reads.
module lcd_panel_model #(
    parameter int BUSY_CYCLES  = 4,
    parameter int CLEAR_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RS,
    input  logic       E,
    input  logic       RW,
    input  logic [7:0] DB,
    output logic [7:0] db_out,
    output logic       db_oe,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_data,
    output logic [4:0] cursor_addr,
    output logic       busy,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       inc_mode,
    output logic       func_8bit,
    output logic       func_2line,
    output logic       overrun
);

    localparam int            CW         = $clog2(CLEAR_CYCLES + 1);
    localparam logic [CW-1:0] BUSY_LOAD  = CW'(BUSY_CYCLES);
    localparam logic [CW-1:0] CLEAR_LOAD = CW'(CLEAR_CYCLES);
    localparam logic [7:0]    BLANK      = 8'h20;

    logic          e_q, e_d;
    logic          rs_q, rs_d, rw_q, rw_d;
    logic [7:0]    db_q, db_d;
    logic [4:0]    ac_q, ac_d;
    logic          inc_q, inc_d;
    logic          disp_q, disp_d, cur_q, cur_d, blink_q, blink_d;
    logic          dl_q, dl_d, n_q, n_d;
    logic          overrun_q, overrun_d;
    logic [CW-1:0] busy_cnt_q, busy_cnt_d;
    logic          sweep_on_q, sweep_on_d;
    logic [4:0]    sweep_idx_q, sweep_idx_d;
    logic [7:0]    db_out_q, db_out_d;
    logic          db_oe_q, db_oe_d;
    logic [7:0]    rd_data_q, rd_data_d;
    logic [7:0]    mem_q [32];
    logic [7:0]    mem_d [32];

    logic       strobe;
    logic       busy_now;
    logic [4:0] ac_step;

    assign strobe   = e_q & ~E;
    assign busy_now = (busy_cnt_q != '0);
    assign ac_step  = inc_q ? (ac_q + 5'd1) : (ac_q - 5'd1);

    always_comb begin
        e_d         = E;
        rs_d        = rs_q;
        rw_d        = rw_q;
        db_d        = db_q;
        ac_d        = ac_q;
        inc_d       = inc_q;
        disp_d      = disp_q;
        cur_d       = cur_q;
        blink_d     = blink_q;
        dl_d        = dl_q;
        n_d         = n_q;
        overrun_d   = overrun_q;
        busy_cnt_d  = busy_now ? (busy_cnt_q - CW'(1)) : '0;
        sweep_on_d  = sweep_on_q;
        sweep_idx_d = sweep_idx_q;
        mem_d       = mem_q;

        if (E) begin
            rs_d = RS;
            rw_d = RW;
            db_d = DB;
        end

        // The sweep runs only while busy, so it never shares a cycle with a bus write.
        if (sweep_on_q) begin
            mem_d[sweep_idx_q] = BLANK;
            sweep_idx_d        = sweep_idx_q + 5'd1;
            if (sweep_idx_q == 5'd31) begin
                sweep_on_d = 1'b0;
            end
        end

        if (strobe) begin
            if (rw_q) begin
                if (rs_q) begin
                    ac_d = ac_step;
                end
            end else if (busy_now) begin
                overrun_d = 1'b1;
            end else if (rs_q) begin
                mem_d[ac_q] = db_q;
                ac_d        = ac_step;
                busy_cnt_d  = BUSY_LOAD;
            end else begin
                if (db_q != 8'h00) begin
                    busy_cnt_d = BUSY_LOAD;
                end
                casez (db_q)
                    8'b1???????: ac_d = db_q[4:0];
                    8'b001?????: begin
                        dl_d = db_q[4];
                        n_d  = db_q[3];
                    end
                    8'b00001???: begin
                        disp_d  = db_q[2];
                        cur_d   = db_q[1];
                        blink_d = db_q[0];
                    end
                    8'b000001??: inc_d = db_q[1];
                    8'b0000001?: ac_d = 5'd0;
                    8'b00000001: begin
                        ac_d        = 5'd0;
                        inc_d       = 1'b1;
                        sweep_on_d  = 1'b1;
                        sweep_idx_d = 5'd0;
                        busy_cnt_d  = CLEAR_LOAD;
                    end
                    default: ;
                endcase
            end
        end

        db_oe_d   = E & RW;
        db_out_d  = (E & RW) ? (RS ? mem_q[ac_q] : {busy_now, 2'b00, ac_q}) : 8'h00;
        rd_data_d = mem_q[rd_addr];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            e_q         <= 1'b0;
            rs_q        <= 1'b0;
            rw_q        <= 1'b0;
            db_q        <= 8'h00;
            ac_q        <= 5'd0;
            inc_q       <= 1'b1;
            disp_q      <= 1'b0;
            cur_q       <= 1'b0;
            blink_q     <= 1'b0;
            dl_q        <= 1'b0;
            n_q         <= 1'b0;
            overrun_q   <= 1'b0;
            busy_cnt_q  <= '0;
            sweep_on_q  <= 1'b0;
            sweep_idx_q <= 5'd0;
            db_out_q    <= 8'h00;
            db_oe_q     <= 1'b0;
            rd_data_q   <= 8'h00;
            for (int i = 0; i < 32; i++) begin
                mem_q[i] <= BLANK;
            end
        end else begin
            e_q         <= e_d;
            rs_q        <= rs_d;
            rw_q        <= rw_d;
            db_q        <= db_d;
            ac_q        <= ac_d;
            inc_q       <= inc_d;
            disp_q      <= disp_d;
            cur_q       <= cur_d;
            blink_q     <= blink_d;
            dl_q        <= dl_d;
            n_q         <= n_d;
            overrun_q   <= overrun_d;
            busy_cnt_q  <= busy_cnt_d;
            sweep_on_q  <= sweep_on_d;
            sweep_idx_q <= sweep_idx_d;
            db_out_q    <= db_out_d;
            db_oe_q     <= db_oe_d;
            rd_data_q   <= rd_data_d;
            mem_q       <= mem_d;
        end
    end

    assign db_out      = db_out_q;
    assign db_oe       = db_oe_q;
    assign rd_data     = rd_data_q;
    assign cursor_addr = ac_q;
    assign busy        = busy_now;
    assign disp_on     = disp_q;
    assign cursor_on   = cur_q;
    assign blink_on    = blink_q;
    assign inc_mode    = inc_q;
    assign func_8bit   = dl_q;
    assign func_2line  = n_q;
    assign overrun     = overrun_q;

endmodule

// File: doc/lcd_panel_model.md
# lcd_panel_model

Responder end of the HD44780-style parallel LCD bus driven by `lcd_disp_interface`. The block samples RS/E/RW/DB in the system clock domain and executes each bus transfer on the falling edge of E. It decodes the instruction subset the clock display uses, keeps a 32-byte DDRAM image with cursor and busy emulation, and answers busy-flag and data reads. It is synthesizable, and it serves both as the simulation partner for the LCD driver and as an on-chip mirror of display contents.

## Interface
- `BUSY_CYCLES`, 4: busy duration in clk cycles after any executed write except clear.
- `CLEAR_CYCLES`, 64: busy duration after clear display; must be >= 32.
- `clk` input 1: system clock; all logic is on its rising edge.
- `rst` input 1: reset, asynchronous and active-low.
- `RS` input 1: register select; 0 = instruction, 1 = data.
- `E` input 1: enable strobe, synchronous to `clk`.
- `RW` input 1: 0 = write, 1 = read.
- `DB` input 8: bus data from the driver.
- `db_out` output 8: read data returned to the driver.
- `db_oe` output 1: high while `E`=1 and `RW`=1; `db_out` is valid only then.
- `rd_addr` input 5: side read address into DDRAM.
- `rd_data` output 8: DDRAM[`rd_addr`], registered, 1-cycle latency.
- `cursor_addr` output 5: current address counter (AC).
- `busy` output 1: busy flag.
- `disp_on`, `cursor_on`, `blink_on` outputs 1 each: the D, C and B bits from display control.
- `inc_mode` output 1: the I/D bit from entry mode.
- `func_8bit`, `func_2line` outputs 1 each: the DL and N bits from function set.
- `overrun` output 1: sticky; set when a write strobe arrives while busy.

## Operation
- Strobe detect: `e_q` is E registered. `strobe` = `e_q` & ~E.
- RS, RW and DB are captured every cycle E=1. A strobe uses the last values captured while E was high.
- Write strobe with busy=1: the command is dropped and `overrun` is set. Otherwise it is decoded as follows.
- RS=0 decode uses priority on the highest set bit:
  - 1xxxxxxx: set DDRAM address; AC = DB[4:0]. DB[6:5] are ignored.
  - 001xxxxx: function set; DL = DB[4], N = DB[3].
  - 00001xxx: display control; D = DB[2], C = DB[1], B = DB[0].
  - 000001xx: entry mode; I/D = DB[1]. S is ignored.
  - 0000001x: return home; AC = 0.
  - 00000001: clear display; AC = 0, I/D = 1, all DDRAM entries are set to 0x20.
  - 01xxxxxx (CGRAM) and 0001xxxx (shift): accepted and set busy, with no other effect.
  - 00000000: ignored; busy is not set.
- RS=1 write: DDRAM[AC] = DB. AC then steps +1 if I/D=1, else -1, modulo 32 (31+1 wraps to 0, 0-1 wraps to 31).
- Reads (RW=1) are never dropped and never set `overrun`.
  - RS=0: `db_out` = {busy, 2'b00, AC}.
  - RS=1: `db_out` = DDRAM[AC]. On the strobe, AC steps as for a data write.
- Clear implementation: a 5-bit sweep index writes 0x20 to one entry per cycle, starting the cycle after the strobe, for 32 cycles. Busy stays high for CLEAR_CYCLES cycles total.
- Data writes are dropped during a clear (busy), so the sweep never collides with a bus write.
- Side read: `rd_data` is read-before-write. If the same cycle writes `rd_addr`, `rd_data` shows the old value.

## Timing
- Reset values:
  - DDRAM: all entries 0x20.
  - AC 0, `inc_mode` 1.
  - `busy`, `overrun`, `db_oe`, `db_out`, `rd_data`, D/C/B, DL, N: all 0.
  - `e_q` 0. The sweep is idle.
- Reset asserted mid-clear or while busy: the operation aborts and every register returns to its reset value.
- Command execution: the strobe occurs in cycle T. AC, the mode bits and DDRAM update at the end of T. `busy` reads 1 from T+1.
- Busy duration: `busy` is high for exactly BUSY_CYCLES cycles (T+1 .. T+BUSY_CYCLES), or CLEAR_CYCLES cycles for clear.
- A strobe in cycle T+BUSY_CYCLES+1 is accepted.
- `db_oe` and `db_out` are registered: they are valid from the cycle after E rises with RW=1, and drop the cycle after E falls.
- A strobe in the same cycle busy expires (busy=1 in that cycle) is a drop.
- E held high indefinitely: no strobe and no execution.
- A strobe coinciding with reset deassertion is ignored (`e_q`=0).

## Test plan
- Init sequence: 0x38, 0x0C, 0x06, 0x01 with RS=0, each strobe spaced ≥ CLEAR_CYCLES+2 cycles.
  - Expect `func_8bit`=1, `func_2line`=1, `disp_on`=1, `cursor_on`=0, `inc_mode`=1, AC=0.
  - After the clear, DDRAM[0..31] = 0x20.
- After init, write data "12:34:56" (0x31 0x32 0x3A 0x33 0x34 0x3A 0x35 0x36) starting from AC=4.
  - Expect DDRAM[4..11] to hold those bytes and AC=12.
  - Then send 0x03: AC=0, DDRAM unchanged.
- Wrap-around: 0x9F then data 0xAA gives DDRAM[31]=0xAA and AC=0.
  - Entry mode 0x04, then data 0x55 at AC=0: DDRAM[0]=0x55 and AC=31.
- Overrun: data strobe, then a second strobe 2 cycles later with BUSY_CYCLES=4.
  - Second write is dropped and `overrun`=1.
  - Busy-flag read in that window returns `db_out`[7]=1 with AC in [4:0].
- Clear followed by `rd_addr` scan: every DDRAM[i] changes to 0x20 within 33 cycles of the strobe; `busy` is high for exactly 64 cycles.
- Assert `rst` low 10 cycles into a clear: all outputs and DDRAM return to reset values immediately; no further sweep writes after release.
